password_lock_ctrl: RTL and testbench

Parametrised digital lock controller for the FPGA lock system. It accepts a multi-digit code one digit per key strobe, then compares the full entry against a stored code. It drives an unlock window, a wrong-code pulse and a lockout alarm with a bounded retry count. tries_left feeds the existing seven-segment counter decoder.

---
 rtl/password_lock_ctrl_if.sv | 30 +++
 rtl/password_lock_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_password_lock_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/password_lock_ctrl_if.sv
// Keypad strobe and lock status bundle for password_lock_ctrl.
// With PW_CHANGE_EN defined it also carries the prog_req/prog_done code-change handshake.
interface password_lock_ctrl_if #(
   parameter int N_DIGITS  = 4,
   parameter int DIGIT_W   = 4,
   parameter int MAX_TRIES = 5
);
   logic                             key_valid;
   logic [DIGIT_W-1:0]               key_code;
   logic                             unlocked;
   logic                             wrong;
   logic                             alarm;
   logic [$clog2(MAX_TRIES+1)-1:0]   tries_left;
   logic [$clog2(N_DIGITS+1)-1:0]    digit_cnt;
   logic                             busy;
`ifdef PW_CHANGE_EN
   logic                             prog_req;
   logic                             prog_done;

   modport master (output key_valid, key_code, prog_req,
                   input  unlocked, wrong, alarm, tries_left, digit_cnt, busy, prog_done);
   modport slave  (input  key_valid, key_code, prog_req,
                   output unlocked, wrong, alarm, tries_left, digit_cnt, busy, prog_done);
`else
   modport master (output key_valid, key_code,
                   input  unlocked, wrong, alarm, tries_left, digit_cnt, busy);
   modport slave  (input  key_valid, key_code,
                   output unlocked, wrong, alarm, tries_left, digit_cnt, busy);
`endif
endinterface

// File: rtl/password_lock_ctrl.sv
// Code lock: collects N_DIGITS keys, compares against the stored code, drives unlock/wrong/alarm.
// Define PW_CHANGE_EN to allow rewriting the code (state PROG) while the lock is open.
module password_lock_ctrl #(
   parameter int N_DIGITS    = 4,
   parameter int DIGIT_W     = 4,
   parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h8124,
   parameter int MAX_TRIES   = 5,
   parameter int UNLOCK_CYC  = 8,
   parameter int LOCKOUT_CYC = 16,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic               clk,
   input  logic               rst,
   password_lock_ctrl_if.slave bus
);
   localparam int CODE_W    = N_DIGITS * DIGIT_W;
   localparam int TRY_W     = $clog2(MAX_TRIES + 1);
   localparam int DCNT_W    = $clog2(N_DIGITS + 1);
   localparam int TMR_MAX_A = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYC) ? TMR_MAX_A : TIMEOUT_CYC;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT, S_PROG
   } state_t;

   state_t              state_reg, state_next;
   logic [TMR_W-1:0]    timer_reg, timer_next;
   logic [DCNT_W-1:0]   digit_cnt_reg, digit_cnt_next;
   logic [TRY_W-1:0]    tries_reg, tries_next;
   logic [DIGIT_W-1:0]  entry_reg [N_DIGITS];
   logic [CODE_W-1:0]   entry_word;
   logic [CODE_W-1:0]   code_word;
   logic                key_acc;
   logic                last_digit;
   logic                code_match;
   logic                state_change;

   assign key_acc    = bus.key_valid &&
                       (state_reg == S_IDLE || state_reg == S_ENTRY || state_reg == S_PROG);
   assign last_digit = (digit_cnt_reg == DCNT_W'(N_DIGITS - 1));
   assign code_match = (entry_word == code_word);

   // Digit field gi sits MS-first; digit_cnt selects which field the current key lands in.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_field
         localparam int HI = CODE_W - 1 - gi * DIGIT_W;
         assign entry_word[HI -: DIGIT_W] = entry_reg[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               entry_reg[gi] <= '0;
            end else if (key_acc) begin
               if (digit_cnt_reg == DCNT_W'(gi))
                  entry_reg[gi] <= bus.key_code;
               else if (state_reg == S_IDLE)
                  entry_reg[gi] <= '0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         timer_reg     <= '0;
         digit_cnt_reg <= '0;
         tries_reg     <= TRY_W'(MAX_TRIES);
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         digit_cnt_reg <= digit_cnt_next;
         tries_reg     <= tries_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:
            if (key_acc) state_next = last_digit ? S_CHECK : S_ENTRY;
         S_ENTRY:
            if (key_acc) begin
               if (last_digit) state_next = S_CHECK;
            end else if (timer_reg == TMR_W'(TIMEOUT_CYC - 1)) begin
               state_next = S_IDLE;
            end
         S_CHECK:
            state_next = code_match ? S_OPEN : S_FAIL;
         S_OPEN: begin
            if (timer_reg == TMR_W'(UNLOCK_CYC - 1)) state_next = S_IDLE;
`ifdef PW_CHANGE_EN
            if (bus.prog_req) state_next = S_PROG;
`endif
         end
         S_FAIL:
            state_next = (tries_reg == '0) ? S_LOCKOUT : S_IDLE;
         S_LOCKOUT:
            if (timer_reg == TMR_W'(LOCKOUT_CYC - 1)) state_next = S_IDLE;
         S_PROG:
            if (key_acc) begin
               if (last_digit) state_next = S_IDLE;
            end else if (timer_reg == TMR_W'(TIMEOUT_CYC - 1)) begin
               state_next = S_IDLE;
            end
         default:
            state_next = S_IDLE;
      endcase
   end

   assign state_change = (state_next != state_reg);

   // One timer serves the unlock window, lockout and the idle-key timeout; any key restarts it.
   always_comb begin
      timer_next = timer_reg + TMR_W'(1);
      if (state_change || key_acc || state_reg == S_IDLE ||
          state_reg == S_CHECK || state_reg == S_FAIL)
         timer_next = '0;
   end

   always_comb begin
      digit_cnt_next = digit_cnt_reg;
      if (key_acc) digit_cnt_next = digit_cnt_reg + DCNT_W'(1);
      if (state_change &&
          (state_next == S_IDLE || state_next == S_OPEN || state_next == S_FAIL))
         digit_cnt_next = '0;
   end

   // The decrement lands on entry to FAIL so the FAIL cycle can decide on lockout.
   always_comb begin
      tries_next = tries_reg;
      if (state_reg == S_CHECK) begin
         if (code_match)
            tries_next = TRY_W'(MAX_TRIES);
         else if (tries_reg != '0)
            tries_next = tries_reg - TRY_W'(1);
      end else if (state_reg == S_LOCKOUT && state_next == S_IDLE) begin
         tries_next = TRY_W'(MAX_TRIES);
      end
   end

   always_comb begin
      bus.unlocked   = (state_reg == S_OPEN) || (state_reg == S_PROG);
      bus.wrong      = (state_reg == S_FAIL);
      bus.alarm      = (state_reg == S_LOCKOUT);
      bus.busy       = (state_reg == S_CHECK) || (state_reg == S_OPEN) ||
                       (state_reg == S_FAIL)  || (state_reg == S_LOCKOUT);
      bus.tries_left = tries_reg;
      bus.digit_cnt  = digit_cnt_reg;
   end

`ifdef PW_CHANGE_EN
   logic [CODE_W-1:0] captured_word;
   logic [CODE_W-1:0] code_reg;
   logic              prog_done_reg;
   logic              prog_commit;

   // Final digit is not yet in entry_reg on the commit edge, so merge it in combinationally.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_capture
         localparam int HI = CODE_W - 1 - gi * DIGIT_W;
         assign captured_word[HI -: DIGIT_W] =
            (digit_cnt_reg == DCNT_W'(gi)) ? bus.key_code : entry_reg[gi];
      end
   endgenerate

   assign prog_commit = (state_reg == S_PROG) && key_acc && last_digit;

   always_ff @(posedge clk) begin
      if (rst) begin
         code_reg      <= DEFAULT_CODE;
         prog_done_reg <= 1'b0;
      end else begin
         prog_done_reg <= prog_commit;
         if (prog_commit) code_reg <= captured_word;
      end
   end

   assign code_word     = code_reg;
   assign bus.prog_done = prog_done_reg;
`else
   assign code_word = DEFAULT_CODE;
`endif

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Scoreboard bench for password_lock_ctrl: a digit-stream reference model predicts
// unlock/wrong/alarm events; a negedge monitor pops and compares them as they appear.
module tb_password_lock_ctrl;
   localparam int N_DIGITS    = 4;
   localparam int DIGIT_W     = 4;
   localparam int MAX_TRIES   = 5;
   localparam int UNLOCK_CYC  = 8;
   localparam int LOCKOUT_CYC = 16;
   localparam int TIMEOUT_CYC = 32;
   localparam int CODE_W      = N_DIGITS * DIGIT_W;
   localparam logic [CODE_W-1:0] DEFAULT_CODE = 16'h8124;

   localparam int EV_OPEN  = 0;
   localparam int EV_WRONG = 1;
   localparam int EV_ALARM = 2;
   localparam int EV_PROG  = 3;

   typedef struct {
      int kind;
      int at;
      int tries;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   ev_t  exp_q[$];

   int                m_tries;
   logic [CODE_W-1:0] m_code;
   int                m_digits[$];
   int                m_last;
   int                m_free;
   bit                m_prog;
   int                m_open_at;
   bit                prog_active;

   bit pu, pw, pa;
   int run_u, run_w, run_a;
   bit wrong_pending;
   int wrong_tries_exp;

   password_lock_ctrl_if #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) bus ();

   password_lock_ctrl #(
      .N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W), .DEFAULT_CODE(DEFAULT_CODE),
      .MAX_TRIES(MAX_TRIES), .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_tries = MAX_TRIES;
      m_code  = DEFAULT_CODE;
      m_digits.delete();
      m_last  = 0;
      m_free  = 0;
      m_prog  = 0;
      prog_active = 0;
   endtask

   // Lock behaviour as a digit stream: N digits make one attempt; a gap longer than the
   // timeout discards a partial entry; keys before m_free land while the lock is busy.
   task automatic model_key(input int c, input int d, output bit acc, output int dc_exp);
      logic [CODE_W-1:0] word;
      acc = 0;
      dc_exp = 0;
      if (c < m_free) return;
      acc = 1;
      if ((m_digits.size() > 0 || m_prog) && (c - m_last > TIMEOUT_CYC)) begin
         m_digits.delete();
         m_prog = 0;
      end
      m_digits.push_back(d);
      m_last = c;
      dc_exp = m_digits.size();
      if (m_digits.size() == N_DIGITS) begin
         word = '0;
         foreach (m_digits[i]) word = (word << DIGIT_W) | CODE_W'(m_digits[i]);
         m_digits.delete();
         if (m_prog) begin
            m_code = word;
            m_prog = 0;
            dc_exp = 0;
            exp_q.push_back('{EV_PROG, c + 1, m_tries});
            m_free = c + 1;
         end else if (word == m_code) begin
            m_tries = MAX_TRIES;
            exp_q.push_back('{EV_OPEN, c + 2, MAX_TRIES});
            m_open_at = c + 2;
            m_free = c + 2 + UNLOCK_CYC;
         end else begin
            m_tries--;
            exp_q.push_back('{EV_WRONG, c + 2, m_tries});
            if (m_tries == 0) begin
               exp_q.push_back('{EV_ALARM, c + 3, 0});
               m_free  = c + 3 + LOCKOUT_CYC;
               m_tries = MAX_TRIES;
            end else begin
               m_free = c + 3;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int d);
      bit acc;
      int dc_exp;
      int c;
      c = cyc;
      model_key(c, d, acc, dc_exp);
      chk(acc ? "busy_low_on_key" : "busy_high_on_key", int'(bus.busy), acc ? 0 : 1);
      bus.key_valid = 1'b1;
      bus.key_code  = DIGIT_W'(d);
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      chk("digit_cnt", int'(bus.digit_cnt), dc_exp);
      $display("[TB] cyc %0d key %0d %s digit_cnt=%0d tries_left=%0d",
               c, d, acc ? "taken" : "ignored", bus.digit_cnt, bus.tries_left);
   endtask

   task automatic enter(input logic [CODE_W-1:0] code, input int gap);
      for (int i = 0; i < N_DIGITS; i++) begin
         press(int'(code[CODE_W-1-i*DIGIT_W -: DIGIT_W]));
         if (i < N_DIGITS - 1) idle(gap);
      end
   endtask

   task automatic wait_free();
      while (cyc < m_free) idle(1);
   endtask

   task automatic do_reset();
      chk("events_drained_before_rst", exp_q.size(), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_unlocked", int'(bus.unlocked), 0);
      chk("rst_wrong", int'(bus.wrong), 0);
      chk("rst_alarm", int'(bus.alarm), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_digit_cnt", int'(bus.digit_cnt), 0);
      chk("rst_tries_left", int'(bus.tries_left), MAX_TRIES);
`ifdef PW_CHANGE_EN
      chk("rst_prog_done", int'(bus.prog_done), 0);
`endif
      $display("[TB] cyc %0d reset applied", cyc);
      rst = 1'b0;
      exp_q.delete();
      model_reset();
   endtask

   task automatic expect_ev(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
         return;
      end
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      $display("[TB] cyc %0d event kind=%0d tries_left=%0d", cyc, kind, bus.tries_left);
      if (kind == EV_OPEN)  chk("tries_on_open", int'(bus.tries_left), MAX_TRIES);
      if (kind == EV_ALARM) chk("tries_on_alarm", int'(bus.tries_left), 0);
      if (kind == EV_WRONG) begin
         wrong_pending   = 1;
         wrong_tries_exp = e.tries;
      end
      if (kind == EV_PROG) prog_active = 0;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst) begin
            pu = 0; pw = 0; pa = 0;
            run_u = 0; run_w = 0; run_a = 0;
            wrong_pending = 0;
         end else begin
            if (wrong_pending) begin
               chk("tries_after_wrong", int'(bus.tries_left), wrong_tries_exp);
               wrong_pending = 0;
            end
            if (bus.unlocked) run_u++;
            else if (pu) begin
               if (!prog_active) chk("unlock_len", run_u, UNLOCK_CYC);
               run_u = 0;
            end
            if (bus.wrong) run_w++;
            else if (pw) begin
               chk("wrong_len", run_w, 1);
               run_w = 0;
            end
            if (bus.alarm) run_a++;
            else if (pa) begin
               chk("alarm_len", run_a, LOCKOUT_CYC);
               chk("tries_after_lockout", int'(bus.tries_left), MAX_TRIES);
               run_a = 0;
            end
            if (bus.unlocked && !pu) expect_ev(EV_OPEN);
            if (bus.wrong && !pw)    expect_ev(EV_WRONG);
            if (bus.alarm && !pa)    expect_ev(EV_ALARM);
`ifdef PW_CHANGE_EN
            if (bus.prog_done)       expect_ev(EV_PROG);
`endif
            pu = bus.unlocked;
            pw = bus.wrong;
            pa = bus.alarm;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin : stim
      bus.key_valid = 1'b0;
      bus.key_code  = '0;
`ifdef PW_CHANGE_EN
      bus.prog_req  = 1'b0;
`endif
      model_reset();
      do_reset();

      // correct code, then one wrong code
      enter(DEFAULT_CODE, 0);
      wait_free();
      chk("tries_after_open", int'(bus.tries_left), m_tries);
      enter(16'h8125, 0);
      wait_free();
      chk("tries_after_one_wrong", int'(bus.tries_left), m_tries);

      // five wrong entries from full tries -> lockout, keys ignored inside it
      enter(DEFAULT_CODE, 1);
      wait_free();
      for (int k = 0; k < MAX_TRIES; k++) begin
         enter(CODE_W'(16'h8125 + k), 1);
         if (k < MAX_TRIES - 1) wait_free();
      end
      idle(4);
      repeat (3) press($urandom_range(0, 15));
      wait_free();
      chk("tries_after_lockout_idle", int'(bus.tries_left), m_tries);
      enter(DEFAULT_CODE, 0);
      wait_free();

      // idle timeout boundary: 32 idle cycles discard, 31 do not
      press(8);
      press(1);
      idle(TIMEOUT_CYC);
      chk("timeout_digit_cnt", int'(bus.digit_cnt), 0);
      chk("timeout_tries_kept", int'(bus.tries_left), m_tries);
      press(8);
      press(1);
      idle(TIMEOUT_CYC - 1);
      chk("pre_timeout_digit_cnt", int'(bus.digit_cnt), 2);
      press(2);
      press(4);
      wait_free();

      // reset mid-entry and mid-lockout
      press(8);
      press(1);
      press(2);
      do_reset();
      for (int k = 0; k < MAX_TRIES; k++) begin
         enter(16'h1234, 0);
         if (k < MAX_TRIES - 1) wait_free();
      end
      idle(6);
      chk("alarm_before_rst", int'(bus.alarm), 1);
      do_reset();
      enter(DEFAULT_CODE, 2);
      wait_free();

`ifdef PW_CHANGE_EN
      begin
         int p;
         enter(DEFAULT_CODE, 0);
         while (cyc < m_open_at + 1) idle(1);
         p = cyc;
         bus.prog_req = 1'b1;
         @(posedge clk);
         #1;
         bus.prog_req = 1'b0;
         m_prog = 1;
         m_digits.delete();
         m_last = p;
         m_free = p + 1;
         prog_active = 1;
         enter(16'h3307, 1);
         idle(2);
         enter(DEFAULT_CODE, 0);
         wait_free();
         enter(16'h3307, 0);
         wait_free();
         do_reset();
         enter(DEFAULT_CODE, 0);
         wait_free();
      end
`endif

      // randomized entries: mix of correct/random codes, random gaps, keys while busy
      for (int t = 0; t < 60; t++) begin
         logic [CODE_W-1:0] word;
         word = ($urandom_range(0, 2) == 0) ? m_code : CODE_W'($urandom);
         for (int i = 0; i < N_DIGITS; i++) begin
            press(int'(word[CODE_W-1-i*DIGIT_W -: DIGIT_W]));
            if (i < N_DIGITS - 1) begin
               if ($urandom_range(0, 9) == 0) idle(TIMEOUT_CYC - 1 + $urandom_range(0, 2));
               else idle($urandom_range(0, 2));
            end
         end
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 3)) press($urandom_range(0, 15));
         wait_free();
      end

      idle(TIMEOUT_CYC + 8);
      chk("events_outstanding", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
